// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg
// Shared definitions for the hiddenCPU controller: opcode constants, FSM
// state encodings and the layout of the instruction word fields.
// No ports; imported by the interface, the register file and the top.

package cpu_control_pkg;

   // Width of an instruction / immediate word fetched from program memory
   localparam int INSTR_W = 8;

   // The decoded fields (op, rd, rs) occupy instr[7:2]; instr[1:0] is ignored
   localparam int FIELD_HI = 7;
   localparam int FIELD_LO = 2;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_XOR   = 2'b10;
   localparam logic [1:0] OP_MOVBR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_EXEC,
      S_IMM_WAIT
   } state_t;

   // Packed in instruction-bit order: op = [7:6], rd = [5:4], rs = [3:2]
   typedef struct packed {
      logic [1:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
   } instr_t;

   function automatic instr_t decode(input logic [FIELD_HI:FIELD_LO] fields);
      return instr_t'(fields);
   endfunction

endpackage

// File: rtl/cpu_control_if.sv
// cpu_control_if
// Bundles the instruction-memory handshake and the ALU connection of the
// hiddenCPU controller.
//   master : controller side (drives imem_req/addr and the ALU operands)
//   slave  : memory + ALU side (drives imem_valid/data and ALU results)
// Parameter PC_W sets the fetch address width.

interface cpu_control_if
   import cpu_control_pkg::*;
#(
   parameter int PC_W = 8
);

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_data;

   logic [1:0]         alu_opcode;
   logic [3:0]         alu_addrs;
   logic [7:0]         alu_din0;
   logic [7:0]         alu_din1;
   logic [7:0]         alu_dout;
   logic               alu_carry;
   logic               alu_borrow;
   logic               alu_bcf;
   logic               alu_bbf;
   logic               alu_buc;
   logic               alu_toggle;

   modport master (
      output imem_req, imem_addr, alu_opcode, alu_addrs, alu_din0, alu_din1,
      input  imem_valid, imem_data, alu_dout, alu_carry, alu_borrow,
             alu_bcf, alu_bbf, alu_buc, alu_toggle
   );

   modport slave (
      input  imem_req, imem_addr, alu_opcode, alu_addrs, alu_din0, alu_din1,
      output imem_valid, imem_data, alu_dout, alu_carry, alu_borrow,
             alu_bcf, alu_bbf, alu_buc, alu_toggle
   );

endinterface

// File: rtl/cpu_control_regfile.sv
// cpu_control_regfile
// 4x8 register file with two combinational read ports and one synchronous
// write port. R0-R2 are internal; R3 is memory-mapped I/O: reads return
// io_in, writes land in the io_out register.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears R0-R2, io_out)
//   raddr0/rdata0     read port 0
//   raddr1/rdata1     read port 1
//   we/waddr/wdata    write port
//   io_in, io_out     external input / output register behind R3

module cpu_control_regfile
   import cpu_control_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] raddr0,
   output logic [7:0] rdata0,
   input  logic [1:0] raddr1,
   output logic [7:0] rdata1,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic [7:0] r0;
   logic [7:0] r1;
   logic [7:0] r2;

   // Write port; address 3 is the output port rather than a storage cell
   always_ff @(posedge clk) begin
      if (rst) begin
         r0     <= 8'h00;
         r1     <= 8'h00;
         r2     <= 8'h00;
         io_out <= 8'h00;
      end else if (we) begin
         case (waddr)
            2'd0:    r0     <= wdata;
            2'd1:    r1     <= wdata;
            2'd2:    r2     <= wdata;
            default: io_out <= wdata;
         endcase
      end
   end

   // Read port 0; R3 reads the live external input
   always_comb begin
      rdata0 = io_in;
      case (raddr0)
         2'd0:    rdata0 = r0;
         2'd1:    rdata0 = r1;
         2'd2:    rdata0 = r2;
         default: rdata0 = io_in;
      endcase
   end

   // Read port 1, same mapping as port 0
   always_comb begin
      rdata1 = io_in;
      case (raddr1)
         2'd0:    rdata1 = r0;
         2'd1:    rdata1 = r1;
         2'd2:    rdata1 = r2;
         default: rdata1 = io_in;
      endcase
   end

endmodule

// File: rtl/cpu_control.sv
// cpu_control
// Fetch/decode/sequencing controller of the hiddenCPU core. Fetches 8-bit
// instructions over a req/valid handshake, owns the PC, the register file
// and the carry/borrow flags, drives the combinational ALU and acts on its
// results and branch/toggle requests.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   run          1 = keep fetching; 0 = park in IDLE at the next fetch
//   bus          cpu_control_if.master: imem handshake + ALU connection
//   io_in        external input, read as R3
//   io_out       external output register, written as R3
//   toggle_pin   output inverted by the ALU toggle request
//   pc           current program counter (debug)

module cpu_control
   import cpu_control_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   cpu_control_if.master     bus,
   input  logic [7:0]        io_in,
   output logic [7:0]        io_out,
   output logic              toggle_pin,
   output logic [PC_W-1:0]   pc
);

   state_t          state;
   instr_t          ir;
   logic            carry_flag;
   logic            borrow_flag;
   logic            br_buc;
   logic            br_bcf;
   logic            br_bbf;
   logic            imem_req_q;
   logic [PC_W-1:0] imem_addr_q;

   logic            is_movbr;
   logic            branch_req;
   logic            reg_we;
   logic            imm_taken;
   logic [1:0]      raddr0;
   logic [7:0]      rdata0;
   logic [7:0]      rdata1;
   logic [PC_W-1:0] pc_plus1;
   logic [PC_W-1:0] pc_plus2;

   assign is_movbr   = (ir.op == OP_MOVBR);
   assign branch_req = is_movbr && (bus.alu_bcf || bus.alu_bbf || bus.alu_buc);

   // Any branch or toggle request suppresses the mov write-back
   assign reg_we = (state == S_EXEC) && !(is_movbr && (branch_req || bus.alu_toggle));

   // mov/branch reads its single source through port 0
   assign raddr0 = is_movbr ? ir.rs : ir.rd;

   assign pc_plus1 = pc + PC_W'(1);
   assign pc_plus2 = pc + PC_W'(2);

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.alu_opcode = ir.op;
   assign bus.alu_addrs  = {ir.rd, ir.rs};
   assign bus.alu_din0   = rdata0;
   assign bus.alu_din1   = is_movbr ? 8'h00 : rdata1;

   // Branch resolution uses the requests latched in EXEC, buc > bcf > bbf
   always_comb begin
      imm_taken = 1'b0;
      if (br_buc) begin
         imm_taken = 1'b1;
      end else if (br_bcf) begin
         imm_taken = carry_flag;
      end else if (br_bbf) begin
         imm_taken = borrow_flag;
      end
   end

   cpu_control_regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr0 (raddr0),
      .rdata0 (rdata0),
      .raddr1 (ir.rs),
      .rdata1 (rdata1),
      .we     (reg_we),
      .waddr  (ir.rd),
      .wdata  (bus.alu_dout),
      .io_in  (io_in),
      .io_out (io_out)
   );

   // Sequencer: imem_req/imem_addr are registered, so the request becomes
   // visible in WAIT/IMM_WAIT and drops in the cycle after valid is taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_FETCH;
         pc          <= RESET_PC;
         ir          <= '0;
         carry_flag  <= 1'b0;
         borrow_flag <= 1'b0;
         br_buc      <= 1'b0;
         br_bcf      <= 1'b0;
         br_bbf      <= 1'b0;
         toggle_pin  <= 1'b0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_PC;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  state <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (run) begin
                  imem_req_q  <= 1'b1;
                  imem_addr_q <= pc;
                  state       <= S_WAIT;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_WAIT: begin
               if (bus.imem_valid) begin
                  ir         <= decode(bus.imem_data[FIELD_HI:FIELD_LO]);
                  imem_req_q <= 1'b0;
                  state      <= S_EXEC;
               end
            end

            S_EXEC: begin
               if (is_movbr && bus.alu_toggle) begin
                  toggle_pin <= ~toggle_pin;
               end
               if (branch_req) begin
                  br_buc      <= bus.alu_buc;
                  br_bcf      <= bus.alu_bcf;
                  br_bbf      <= bus.alu_bbf;
                  imem_req_q  <= 1'b1;
                  imem_addr_q <= pc_plus1;
                  state       <= S_IMM_WAIT;
               end else begin
                  case (ir.op)
                     OP_ADD:  carry_flag  <= bus.alu_carry;
                     OP_SUB:  borrow_flag <= bus.alu_borrow;
                     OP_XOR:  ;
                     default: ;
                  endcase
                  pc    <= pc_plus1;
                  state <= S_FETCH;
               end
            end

            S_IMM_WAIT: begin
               if (bus.imem_valid) begin
                  imem_req_q <= 1'b0;
                  pc         <= imm_taken ? PC_W'(bus.imem_data) : pc_plus2;
                  state      <= S_FETCH;
               end
            end

            default: begin
               imem_req_q <= 1'b0;
               state      <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control
// Directed testbench for cpu_control. A small program memory model answers
// the fetch handshake with a programmable wait count; the ALU is a stub
// whose outputs are set by hand for each executed instruction.

module tb_cpu_control;
   import cpu_control_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [7:0] io_in;
   logic [7:0] io_out;
   logic       toggle_pin;
   logic [7:0] pc;

   logic [7:0] imem [0:255];
   int         memDelay      = 0;
   int         waitCount     = 0;
   logic       spuriousValid = 1'b0;

   int compareCount  = 0;
   int mismatchCount = 0;

   cpu_control_if #(.PC_W(8)) bus ();

   cpu_control #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .bus        (bus),
      .io_in      (io_in),
      .io_out     (io_out),
      .toggle_pin (toggle_pin),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   // Program memory: answers a request after memDelay wait cycles; with no
   // request it only drives the optional spurious valid
   always @(negedge clk) begin
      if (bus.imem_req) begin
         if (waitCount >= memDelay) begin
            bus.imem_valid = 1'b1;
            bus.imem_data  = imem[bus.imem_addr];
         end else begin
            bus.imem_valid = 1'b0;
            bus.imem_data  = 8'h00;
            waitCount++;
         end
      end else begin
         waitCount      = 0;
         bus.imem_valid = spuriousValid;
         bus.imem_data  = 8'hFF;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] dout, input logic carry,
                                input logic borrow, input logic bcf,
                                input logic bbf, input logic buc,
                                input logic tog);
      bus.alu_dout   = dout;
      bus.alu_carry  = carry;
      bus.alu_borrow = borrow;
      bus.alu_bcf    = bcf;
      bus.alu_bbf    = bbf;
      bus.alu_buc    = buc;
      bus.alu_toggle = tog;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // From a FETCH cycle: step into WAIT, hold until the word is taken, end in EXEC
   task automatic fetchToExec(input logic [7:0] expAddr);
      int n = 0;
      tick();
      checkOutput("wait_req", bus.imem_req, 1);
      checkOutput("wait_addr", bus.imem_addr, expAddr);
      tick();
      while (bus.imem_req && n < 20) begin
         checkOutput("hold_addr", bus.imem_addr, expAddr);
         tick();
         n++;
      end
      checkOutput("exec_reached", bus.imem_req, 0);
   endtask

   // From IMM_WAIT: check the immediate request, wait for it, check new pc
   task automatic immToFetch(input logic [7:0] expAddr, input logic [7:0] expPc);
      int n = 0;
      checkOutput("imm_req", bus.imem_req, 1);
      checkOutput("imm_addr", bus.imem_addr, expAddr);
      tick();
      while (bus.imem_req && n < 20) begin
         tick();
         n++;
      end
      checkOutput("imm_done", bus.imem_req, 0);
      checkOutput("branch_pc", pc, expPc);
   endtask

   // Global time limit so the bench always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // Directed program with hand-computed results
   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 8'h00;
      imem[8'h00] = 8'h0C;
      imem[8'h01] = 8'h00;
      imem[8'h02] = 8'hC0;
      imem[8'h03] = 8'h40;
      imem[8'h40] = 8'h41;
      imem[8'h41] = 8'h00;
      imem[8'h42] = 8'hC0;
      imem[8'h43] = 8'h80;
      imem[8'h44] = 8'h00;
      imem[8'h45] = 8'h80;
      imem[8'h46] = 8'hC0;
      imem[8'h47] = 8'hFE;
      imem[8'hFE] = 8'hC0;
      imem[8'hFF] = 8'h77;
      imem[8'h10] = 8'hF0;
      imem[8'h11] = 8'hC4;
      imem[8'h12] = 8'h00;
      imem[8'h13] = 8'h00;
      imem[8'h14] = 8'h00;

      rst   = 1'b1;
      run   = 1'b1;
      io_in = 8'h25;
      applyStimulus(8'h00, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_pc", pc, 8'h00);
      checkOutput("rst_req", bus.imem_req, 0);
      checkOutput("rst_io_out", io_out, 8'h00);
      checkOutput("rst_toggle", toggle_pin, 0);

      // add R0,R3 : R0 = 0x25
      fetchToExec(8'h00);
      checkOutput("add_opcode", bus.alu_opcode, 2'b00);
      checkOutput("add_addrs", bus.alu_addrs, 4'h3);
      checkOutput("add_din0", bus.alu_din0, 8'h00);
      checkOutput("add_din1", bus.alu_din1, 8'h25);
      applyStimulus(8'h25, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("add_pc", pc, 8'h01);

      // add R0,R0 : reads back 0x25, sets carry
      fetchToExec(8'h01);
      checkOutput("r0_din0", bus.alu_din0, 8'h25);
      checkOutput("r0_din1", bus.alu_din1, 8'h25);
      applyStimulus(8'h4A, 1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("add2_pc", pc, 8'h02);

      // bcf with carry=1 : taken to 0x40, no mov write
      fetchToExec(8'h02);
      checkOutput("br_opcode", bus.alu_opcode, 2'b11);
      checkOutput("br_din0", bus.alu_din0, 8'h4A);
      checkOutput("br_din1", bus.alu_din1, 8'h00);
      applyStimulus(8'h99, 0, 0, 1, 0, 0, 0);
      tick();
      immToFetch(8'h03, 8'h40);

      // sub R0,R0 : R0 survived the branch; clears borrow, keeps carry
      fetchToExec(8'h40);
      checkOutput("sub_opcode", bus.alu_opcode, 2'b01);
      checkOutput("sub_din0", bus.alu_din0, 8'h4A);
      applyStimulus(8'h00, 1, 0, 0, 0, 0, 0);
      tick();
      checkOutput("sub_pc", pc, 8'h41);

      // add with carry=0, then bcf not taken : pc+2
      fetchToExec(8'h41);
      checkOutput("add3_din0", bus.alu_din0, 8'h00);
      applyStimulus(8'h10, 0, 0, 0, 0, 0, 0);
      tick();
      fetchToExec(8'h42);
      applyStimulus(8'h99, 0, 0, 1, 0, 0, 0);
      tick();
      immToFetch(8'h43, 8'h44);

      // add sets carry, xor must leave it alone, bcf then taken to 0xFE
      fetchToExec(8'h44);
      applyStimulus(8'h10, 1, 0, 0, 0, 0, 0);
      tick();
      fetchToExec(8'h45);
      checkOutput("xor_opcode", bus.alu_opcode, 2'b10);
      checkOutput("xor_din0", bus.alu_din0, 8'h10);
      applyStimulus(8'h10, 0, 1, 0, 0, 0, 0);
      tick();
      fetchToExec(8'h46);
      applyStimulus(8'h99, 0, 0, 1, 0, 0, 0);
      tick();
      immToFetch(8'h47, 8'hFE);

      // bbf at 0xFE with borrow=0 : not taken, pc wraps to 0x00
      fetchToExec(8'hFE);
      applyStimulus(8'h99, 0, 0, 0, 1, 0, 0);
      tick();
      immToFetch(8'hFF, 8'h00);

      // buc outranks bbf (borrow=0) : taken to 0x10
      imem[8'h00] = 8'hC0;
      imem[8'h01] = 8'h10;
      fetchToExec(8'h00);
      applyStimulus(8'h99, 0, 0, 0, 1, 1, 0);
      tick();
      immToFetch(8'h01, 8'h10);

      // mov R3,R0 : io_out = 0xA5
      fetchToExec(8'h10);
      checkOutput("mov_din0", bus.alu_din0, 8'h10);
      checkOutput("mov_din1", bus.alu_din1, 8'h00);
      applyStimulus(8'hA5, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("mov_io_out", io_out, 8'hA5);
      checkOutput("mov_pc", pc, 8'h11);

      // toggle only : pin flips, R0 not written
      fetchToExec(8'h11);
      applyStimulus(8'h33, 0, 0, 0, 0, 0, 1);
      tick();
      checkOutput("tog_pin", toggle_pin, 1);
      checkOutput("tog_pc", pc, 8'h12);

      // slow memory (3 wait cycles); R0 still 0x10 after the toggle
      memDelay = 3;
      fetchToExec(8'h12);
      checkOutput("tog_nowrite", bus.alu_din0, 8'h10);
      applyStimulus(8'h10, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("slow_pc", pc, 8'h13);

      // run=0 during WAIT : instruction completes, then parks in IDLE
      memDelay = 2;
      tick();
      checkOutput("stop_req", bus.imem_req, 1);
      run = 1'b0;
      for (int n = 0; n < 20 && bus.imem_req; n++) tick();
      checkOutput("stop_exec", bus.imem_req, 0);
      applyStimulus(8'h10, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("stop_pc", pc, 8'h14);
      tick();
      spuriousValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("idle_req", bus.imem_req, 0);
         checkOutput("idle_pc", pc, 8'h14);
      end
      spuriousValid = 1'b0;
      run           = 1'b1;
      memDelay      = 5;
      tick();
      checkOutput("resume_fetch", bus.imem_req, 0);
      tick();
      checkOutput("resume_req", bus.imem_req, 1);
      checkOutput("resume_addr", bus.imem_addr, 8'h14);

      // reset while WAIT is still pending
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("wrst_req", bus.imem_req, 0);
      checkOutput("wrst_pc", pc, 8'h00);
      checkOutput("wrst_io_out", io_out, 8'h00);
      checkOutput("wrst_toggle", toggle_pin, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
